// File: rtl/video_frame_packer.sv
// rtl/video_frame_packer.sv - packs the serial video bit stream into words for a ping-pong frame memory
module video_frame_packer #(
  parameter int WORD_W      = 16,
  parameter int FRAME_BITS  = 4800,
  parameter int WORD_ADDR_W = 9
) (
  input  logic                   CLK_40,
  input  logic                   reset,
  input  logic                   data_clk_rising_edge,
  input  logic                   video_data_ready,
  input  logic                   received_bit,
  input  logic                   disp_frame_done,
  input  logic                   frame_abort,
  output logic                   mem_we,
  output logic [WORD_ADDR_W:0]   mem_waddr,
  output logic [WORD_W-1:0]      mem_wdata,
  output logic                   disp_bank,
  output logic                   frame_req,
  output logic                   wr_frame_full,
  output logic                   overflow_err,
  output logic [7:0]             underrun_cnt
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(WORD_W);

  typedef enum logic [1:0] {FILLING, FULL, SWAP} state_t;

  state_t                 state, state_nxt;
  logic                   booted;
  logic                   wr_bank;
  logic [CNT_W-1:0]       bit_cnt;
  logic [POS_W-1:0]       bit_pos;
  logic [WORD_ADDR_W-1:0] word_idx;
  logic [WORD_W-1:0]      shift;
  logic                   bit_strobe, abort_take, take_bit, word_done, frame_done;
  logic                   req_nxt;

  assign bit_strobe = data_clk_rising_edge & video_data_ready;
  assign abort_take = frame_abort & (state != SWAP);
  assign take_bit   = bit_strobe & ~wr_frame_full & ~abort_take;
  assign word_done  = take_bit & (bit_pos == POS_W'(WORD_W - 1));
  assign frame_done = take_bit & (bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) state <= FILLING;
    else       state <= state_nxt;
  end

  // FULL is entered one cycle after the final write, so a frame_done coinciding
  // with that write is still treated as an underrun.
  always_comb begin
    state_nxt = state;
    req_nxt   = ~booted | abort_take;
    case (state)
      FILLING: if (!abort_take && wr_frame_full) state_nxt = FULL;
      FULL: begin
        if (abort_take)           state_nxt = FILLING;
        else if (disp_frame_done) state_nxt = SWAP;
      end
      SWAP:    state_nxt = FILLING;
      default: state_nxt = FILLING;
    endcase
    if (state_nxt == SWAP) req_nxt = 1'b1;
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      booted        <= 1'b0;
      frame_req     <= 1'b0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      wr_bank       <= 1'b1;
      disp_bank     <= 1'b0;
      bit_cnt       <= '0;
      bit_pos       <= '0;
      word_idx      <= '0;
      shift         <= '0;
      wr_frame_full <= 1'b0;
      overflow_err  <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      booted    <= 1'b1;
      frame_req <= req_nxt;
      mem_we    <= word_done;
      mem_waddr <= {wr_bank, word_idx};
      if (word_done) mem_wdata <= {shift[WORD_W-2:0], received_bit};

      if (abort_take) begin
        bit_cnt       <= '0;
        bit_pos       <= '0;
        word_idx      <= '0;
        shift         <= '0;
        wr_frame_full <= 1'b0;
      end else if (take_bit) begin
        shift <= {shift[WORD_W-2:0], received_bit};
        if (frame_done) begin
          bit_cnt       <= '0;
          bit_pos       <= '0;
          word_idx      <= '0;
          wr_frame_full <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (word_done) begin
            bit_pos  <= '0;
            word_idx <= word_idx + WORD_ADDR_W'(1);
          end else begin
            bit_pos <= bit_pos + POS_W'(1);
          end
        end
      end else if (state == SWAP) begin
        disp_bank     <= wr_bank;
        wr_bank       <= ~wr_bank;
        wr_frame_full <= 1'b0;
      end

      if (bit_strobe && wr_frame_full) overflow_err <= 1'b1;

      // Display rescans its old bank when no complete frame is waiting.
      if (disp_frame_done && state == FILLING && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule
